// File: rtl/vram_pkg.sv
// Shared definitions for the text-mode video RAM responder:
// FSM encoding, default depth, byte-lane mapping and service latencies.
package vram_pkg;

    localparam int DEPTH_LOG2_DEF = 11;
    localparam int VID_LAT        = 3;
    localparam int CPU_WR_LAT     = 2;
    localparam int HI_LANE_SHIFT  = 2;

    typedef enum logic [2:0] {
        IDLE,
        VRD,
        VACK,
        CRD,
        CACK,
        CWR
    } state_t;

    // Odd cells occupy the upper two byte lanes of a RAM word.
    function automatic logic [3:0] laneEnable(input logic half, input logic [1:0] be);
        logic [3:0] lanes;
        lanes = {2'b00, be};
        return half ? (lanes << HI_LANE_SHIFT) : lanes;
    endfunction

endpackage

// File: rtl/vram_bram.sv
// Single-port synchronous text RAM with byte-lane write enables and a
// one-cycle registered read; deliberately unreset so it maps onto block RAM.
module vram_bram #(
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                  clk_i,
    input  logic [DEPTH_LOG2-1:0] adr_i,
    input  logic [3:0]            we_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem[adr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        rdata_q <= mem[adr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vram_responder.sv
// Text-RAM owner: arbitrates video word reads against CPU half-word
// accesses and returns one-cycle acknowledges to each side.
module vram_responder
    import vram_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                iClk_100M,
    input  logic                iRst,
    input  logic                iVidRd,
    input  logic [18:0]         iVidAdr,
    output logic [31:0]         oVidData,
    output logic                oVidAck,
    input  logic                iCpuRd,
    input  logic                iCpuWr,
    input  logic [DEPTH_LOG2:0] iCpuAdr,
    input  logic [1:0]          iCpuBE,
    input  logic [15:0]         iCpuData,
    output logic [15:0]         oCpuData,
    output logic                oCpuAck
);

    state_t                state_q, state_d;
    logic                  vidPend_q, vidPend_d;
    logic [DEPTH_LOG2-1:0] vidAdr_q, vidAdr_d;
    logic                  vidOor_q, vidOor_d;
    logic                  cpuPend_q, cpuPend_d;
    logic [DEPTH_LOG2:0]   cpuAdr_q, cpuAdr_d;
    logic [1:0]            cpuBe_q, cpuBe_d;
    logic [15:0]           cpuWdat_q, cpuWdat_d;
    logic                  cpuWr_q, cpuWr_d;
    logic                  lastCpu_q, lastCpu_d;
    logic [DEPTH_LOG2-1:0] ramAdr_q, ramAdr_d;
    logic [31:0]           vidData_q, vidData_d;
    logic                  vidAck_q, vidAck_d;
    logic [15:0]           cpuData_q, cpuData_d;
    logic                  cpuAck_q, cpuAck_d;

    logic                  grantVid, grantCpu, vidBusy, cpuBusy;
    logic [3:0]            ramWe;
    logic [31:0]           ramWdat, ramRdat;

    always_ff @(posedge iClk_100M or posedge iRst) begin
        if (iRst) begin
            state_q   <= IDLE;
            vidPend_q <= 1'b0;
            vidAdr_q  <= '0;
            vidOor_q  <= 1'b0;
            cpuPend_q <= 1'b0;
            cpuAdr_q  <= '0;
            cpuBe_q   <= '0;
            cpuWdat_q <= '0;
            cpuWr_q   <= 1'b0;
            lastCpu_q <= 1'b1;
            ramAdr_q  <= '0;
            vidData_q <= '0;
            vidAck_q  <= 1'b0;
            cpuData_q <= '0;
            cpuAck_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            vidPend_q <= vidPend_d;
            vidAdr_q  <= vidAdr_d;
            vidOor_q  <= vidOor_d;
            cpuPend_q <= cpuPend_d;
            cpuAdr_q  <= cpuAdr_d;
            cpuBe_q   <= cpuBe_d;
            cpuWdat_q <= cpuWdat_d;
            cpuWr_q   <= cpuWr_d;
            lastCpu_q <= lastCpu_d;
            ramAdr_q  <= ramAdr_d;
            vidData_q <= vidData_d;
            vidAck_q  <= vidAck_d;
            cpuData_q <= cpuData_d;
            cpuAck_q  <= cpuAck_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vidPend_d = vidPend_q;
        vidAdr_d  = vidAdr_q;
        vidOor_d  = vidOor_q;
        cpuPend_d = cpuPend_q;
        cpuAdr_d  = cpuAdr_q;
        cpuBe_d   = cpuBe_q;
        cpuWdat_d = cpuWdat_q;
        cpuWr_d   = cpuWr_q;
        lastCpu_d = lastCpu_q;
        ramAdr_d  = ramAdr_q;
        vidData_d = vidData_q;
        vidAck_d  = 1'b0;
        cpuData_d = cpuData_q;
        cpuAck_d  = 1'b0;
        ramWe     = 4'b0000;
        ramWdat   = {cpuWdat_q, cpuWdat_q};
        grantVid  = 1'b0;
        grantCpu  = 1'b0;
        vidBusy   = (state_q == VRD) || (state_q == VACK);
        cpuBusy   = (state_q == CRD) || (state_q == CACK) || (state_q == CWR);

        case (state_q)
            IDLE: begin
                // The tie-break flag only moves on a contended grant, so ties alternate.
                if (vidPend_q && (!cpuPend_q || lastCpu_q)) begin
                    grantVid = 1'b1;
                    ramAdr_d = vidAdr_q;
                    state_d  = VRD;
                    if (cpuPend_q) lastCpu_d = 1'b0;
                end else if (cpuPend_q) begin
                    grantCpu = 1'b1;
                    ramAdr_d = cpuAdr_q[DEPTH_LOG2:1];
                    if (vidPend_q) lastCpu_d = 1'b1;
                    if (cpuWr_q) begin
                        ramWe   = laneEnable(cpuAdr_q[0], cpuBe_q);
                        state_d = CWR;
                    end else begin
                        state_d = CRD;
                    end
                end
            end
            VRD:  state_d = VACK;
            VACK: begin
                vidData_d = vidOor_q ? 32'h0 : ramRdat;
                vidAck_d  = 1'b1;
                state_d   = IDLE;
            end
            CRD:  state_d = CACK;
            CACK: begin
                cpuData_d = cpuAdr_q[0] ? ramRdat[31:16] : ramRdat[15:0];
                cpuAck_d  = 1'b1;
                state_d   = IDLE;
            end
            CWR: begin
                cpuAck_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (grantVid) begin
            vidPend_d = 1'b0;
        end else if (iVidRd && !vidPend_q && !vidBusy) begin
            vidPend_d = 1'b1;
            vidAdr_d  = iVidAdr[DEPTH_LOG2-1:0];
            vidOor_d  = |iVidAdr[18:DEPTH_LOG2];
        end

        // A simultaneous read and write strobe is captured as a write.
        if (grantCpu) begin
            cpuPend_d = 1'b0;
        end else if ((iCpuRd || iCpuWr) && !cpuPend_q && !cpuBusy) begin
            cpuPend_d = 1'b1;
            cpuAdr_d  = iCpuAdr;
            cpuBe_d   = iCpuBE;
            cpuWdat_d = iCpuData;
            cpuWr_d   = iCpuWr;
        end
    end

    vram_bram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) uRam (
        .clk_i  (iClk_100M),
        .adr_i  (ramAdr_d),
        .we_i   (ramWe),
        .wdata_i(ramWdat),
        .rdata_o(ramRdat)
    );

    assign oVidData = vidData_q;
    assign oVidAck  = vidAck_q;
    assign oCpuData = cpuData_q;
    assign oCpuAck  = cpuAck_q;

endmodule

// File: tb/tb_vram_responder.sv
// Directed bench for vram_responder: hand-computed data, ack latencies,
// arbitration order, out-of-range reads and reset behaviour.
module tb_vram_responder;
    import vram_pkg::*;

    logic        iClk_100M = 1'b0;
    logic        iRst;
    logic        iVidRd;
    logic [18:0] iVidAdr;
    logic [31:0] oVidData;
    logic        oVidAck;
    logic        iCpuRd;
    logic        iCpuWr;
    logic [11:0] iCpuAdr;
    logic [1:0]  iCpuBE;
    logic [15:0] iCpuData;
    logic [15:0] oCpuData;
    logic        oCpuAck;

    int          checks = 0;
    int          failures = 0;
    int          bothHigh = 0;
    int          vAt, cAt, vCnt, cCnt;
    logic [31:0] vDat;
    logic [15:0] cDat;

    vram_responder #(.DEPTH_LOG2(11)) dut (
        .iClk_100M(iClk_100M),
        .iRst     (iRst),
        .iVidRd   (iVidRd),
        .iVidAdr  (iVidAdr),
        .oVidData (oVidData),
        .oVidAck  (oVidAck),
        .iCpuRd   (iCpuRd),
        .iCpuWr   (iCpuWr),
        .iCpuAdr  (iCpuAdr),
        .iCpuBE   (iCpuBE),
        .iCpuData (iCpuData),
        .oCpuData (oCpuData),
        .oCpuAck  (oCpuAck)
    );

    always #5 iClk_100M = ~iClk_100M;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one strobe cycle; returns just after the sampling edge.
    task automatic applyStimulus(input logic vRd, input logic [18:0] vAdr, input logic cRd, input logic cWr,
                                 input logic [11:0] cAdr, input logic [1:0] cBe, input logic [15:0] cDat);
        @(negedge iClk_100M);
        iVidRd   = vRd;
        iVidAdr  = vAdr;
        iCpuRd   = cRd;
        iCpuWr   = cWr;
        iCpuAdr  = cAdr;
        iCpuBE   = cBe;
        iCpuData = cDat;
        @(posedge iClk_100M);
        #1;
        iVidRd = 1'b0;
        iCpuRd = 1'b0;
        iCpuWr = 1'b0;
    endtask

    // Observe a fixed window of cycles after the strobe edge, recording acks.
    task automatic watch(input bit reVid);
        vAt = -1;
        cAt = -1;
        vCnt = 0;
        cCnt = 0;
        for (int k = 1; k <= 10; k++) begin
            if (reVid && k == 1) iVidRd = 1'b1;
            @(posedge iClk_100M);
            #1;
            iVidRd = 1'b0;
            if (oVidAck) begin
                vCnt++;
                if (vAt < 0) vAt = k;
                vDat = oVidData;
            end
            if (oCpuAck) begin
                cCnt++;
                if (cAt < 0) cAt = k;
                cDat = oCpuData;
            end
            if (oVidAck && oCpuAck) bothHigh++;
        end
    endtask

    task automatic cpuWrite(input string tag, input logic [11:0] adr, input logic [1:0] be, input logic [15:0] d);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, adr, be, d);
        watch(1'b0);
        checkOutput({tag, "_ackLat"}, cAt, CPU_WR_LAT);
        checkOutput({tag, "_ackCnt"}, cCnt, 1);
    endtask

    task automatic cpuRead(input string tag, input logic [11:0] adr, input logic [15:0] expData);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, adr, 2'b11, 16'h0);
        watch(1'b0);
        checkOutput({tag, "_ackLat"}, cAt, 3);
        checkOutput({tag, "_data"}, {16'h0, cDat}, {16'h0, expData});
    endtask

    task automatic doReset();
        @(negedge iClk_100M);
        iRst = 1'b1;
        @(negedge iClk_100M);
        iRst = 1'b0;
    endtask

    initial begin
        iRst = 1'b1;
        iVidRd = 1'b0;
        iVidAdr = '0;
        iCpuRd = 1'b0;
        iCpuWr = 1'b0;
        iCpuAdr = '0;
        iCpuBE = '0;
        iCpuData = '0;
        repeat (3) @(posedge iClk_100M);
        #1;
        checkOutput("rst_vidAck", oVidAck, 0);
        checkOutput("rst_cpuAck", oCpuAck, 0);
        checkOutput("rst_vidData", oVidData, 0);
        checkOutput("rst_cpuData", {16'h0, oCpuData}, 0);
        @(negedge iClk_100M);
        iRst = 1'b0;

        cpuWrite("wr0", 12'h000, 2'b11, 16'h0741);
        cpuWrite("wr1", 12'h001, 2'b11, 16'h0742);
        applyStimulus(1'b1, 19'h0, 1'b0, 1'b0, '0, '0, '0);
        watch(1'b0);
        checkOutput("vrd0_ackLat", vAt, VID_LAT);
        checkOutput("vrd0_ackCnt", vCnt, 1);
        checkOutput("vrd0_data", vDat, 32'h07420741);

        cpuWrite("wr3", 12'h003, 2'b11, 16'h1234);
        cpuWrite("wr3be", 12'h003, 2'b01, 16'hAB55);
        cpuRead("rd3", 12'h003, 16'h1255);

        doReset();
        applyStimulus(1'b1, 19'h0, 1'b1, 1'b0, 12'h001, 2'b11, 16'h0);
        watch(1'b0);
        checkOutput("tie1_vidAt", vAt, 3);
        checkOutput("tie1_cpuAt", cAt, 6);
        checkOutput("tie1_vidData", vDat, 32'h07420741);
        checkOutput("tie1_cpuData", {16'h0, cDat}, 32'h0742);
        applyStimulus(1'b1, 19'h0, 1'b1, 1'b0, 12'h001, 2'b11, 16'h0);
        watch(1'b0);
        checkOutput("tie2_cpuAt", cAt, 3);
        checkOutput("tie2_vidAt", vAt, 6);

        applyStimulus(1'b1, 19'h00800, 1'b0, 1'b0, '0, '0, '0);
        watch(1'b0);
        checkOutput("oor_ackLat", vAt, VID_LAT);
        checkOutput("oor_ackCnt", vCnt, 1);
        checkOutput("oor_data", vDat, 32'h0);

        applyStimulus(1'b1, 19'h0, 1'b0, 1'b0, '0, '0, '0);
        watch(1'b1);
        checkOutput("restrobe_ackCnt", vCnt, 1);
        checkOutput("restrobe_data", vDat, 32'h07420741);

        applyStimulus(1'b0, '0, 1'b1, 1'b1, 12'h005, 2'b11, 16'hBEEF);
        watch(1'b0);
        checkOutput("rdwr_ackLat", cAt, CPU_WR_LAT);
        checkOutput("rdwr_ackCnt", cCnt, 1);
        cpuRead("rd5", 12'h005, 16'hBEEF);

        applyStimulus(1'b1, 19'h0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge iClk_100M);
        #1;
        iRst = 1'b1;
        #1;
        checkOutput("midrst_vidAck", oVidAck, 0);
        checkOutput("midrst_vidData", oVidData, 0);
        checkOutput("midrst_cpuData", {16'h0, oCpuData}, 0);
        @(negedge iClk_100M);
        iRst = 1'b0;
        watch(1'b0);
        checkOutput("midrst_noAck", vCnt, 0);
        applyStimulus(1'b1, 19'h0, 1'b0, 1'b0, '0, '0, '0);
        watch(1'b0);
        checkOutput("postrst_data0", vDat, 32'h07420741);
        cpuRead("postrst_rd3", 12'h003, 16'h1255);

        checkOutput("acks_never_both", bothHigh, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
